output_port_arbiter: RTL and testbench
======================================

Name: output_port_arbiter

Overview:
- Round-robin wormhole arbiter for one router output port.
- Collects the decoded `router_port_o` requests from the input routers of all N input ports.
- Grants the port to one input at a time and holds the grant from a head flit through its tail flit.
- One instance per output port (N, S, E, W, Local), sitting between the input routers and the output crossbar mux select.

Parameters:
- N_INPUTS, 5, number of requesting input ports (index 0..N_INPUTS-1).
- STALL_MAX, 255, count of consecutive no-transfer cycles while locked before `stall_o` asserts (1..65535).
- CNT_W, 16, width of the completed-packet counter.

Ports:
- clk  input  1  system clock, rising edge.
- arst  input  1  asynchronous reset, active-low.
- req_i  input  N_INPUTS  bit i = input i presents a valid flit destined for this output.
- tail_i  input  N_INPUTS  bit i = presented flit of input i is a tail (or single-flit) flit; ignored when `req_i[i]`=0.
- out_ready_i  input  1  downstream (next hop / local sink) accepts a flit this cycle.
- grant_o  output  N_INPUTS  one-hot grant, registered; drives crossbar select and input-buffer pop.
- owner_o  output  3  binary index of current owner; valid when `locked_o`=1.
- locked_o  output  1  port is held by a packet.
- fire_o  output  1  flit transfer this cycle = `locked_o` & `req_i[owner]` & `out_ready_i`.
- stall_o  output  1  lock held with no transfer for >= STALL_MAX cycles.
- pkt_cnt_o  output  CNT_W  number of completed packets (tail transfers), wraps modulo 2^CNT_W.

Behaviour:
Reset:
- While `arst`=0 (asynchronous): state=IDLE, `grant_o`=0, `owner_o`=0, `locked_o`=0, `stall_o`=0, `pkt_cnt_o`=0, rr_ptr=0, stall_cnt=0.
- Reset mid-packet drops the lock immediately; no flit is counted.

States:
- IDLE: `grant_o`=0, `fire_o`=0.
  - If any `req_i` bit is set, select the first set bit searching from rr_ptr upward, wrapping at N_INPUTS-1 -> 0.
  - Next edge: state=LOCKED, owner=winner, `grant_o`=onehot(winner), `locked_o`=1.
  - Latency: a request seen at edge k yields `grant_o` high after edge k+1. The first transfer is possible in that cycle.
- LOCKED: `grant_o`=onehot(owner), fixed regardless of other requests.
  - `fire_o` is combinational, per the formula above.
  - On `fire_o` with `tail_i[owner]`=1:
    - Next edge: state=IDLE, `grant_o`=0, `locked_o`=0, rr_ptr=(owner+1) mod N_INPUTS, `pkt_cnt_o`+1.
    - This leaves one bubble cycle in IDLE between packets; this is intentional.
  - On `fire_o` with tail=0: stay LOCKED.
  - `req_i[owner]`=0 while LOCKED (owner buffer empty mid-packet): hold lock, no transfer, no release. This is wormhole semantics.
- `req_i` bits of non-owners are ignored while LOCKED; they are never dropped, only deferred.

Stall counter:
- Counts LOCKED cycles with `fire_o`=0.
- Clears to 0 on any `fire_o` and in IDLE.
- Saturates at STALL_MAX.
- `stall_o` is registered: 1 when stall_cnt==STALL_MAX, cleared the edge after the next `fire_o` or on release.

Arithmetic:
- rr_ptr wraps modulo N_INPUTS; it never holds a value >= N_INPUTS.
- `pkt_cnt_o` wraps 2^CNT_W-1 -> 0.
- `owner_o` is zero-extended to 3 bits.

Simultaneous events:
- Tail `fire_o` in the same cycle as new requests: release takes priority. Arbitration happens in the following IDLE cycle using the updated rr_ptr.
- Single-flit packet (head=tail) releases after one transfer.

Invariants (checked by assertion):
- `grant_o` is one-hot or zero.
- `grant_o`!=0 iff `locked_o`.
- `fire_o` implies `out_ready_i`.

Test Plan:
- Reset, then `req_i`=5'b00100, `tail_i`=5'b00100, `out_ready_i`=1 -> `grant_o`=5'b00100 one cycle later, `fire_o`=1 for 1 cycle, `pkt_cnt_o`=1, `locked_o`=0 next cycle, rr_ptr=3.
- All `req_i`=5'b11111, 2-flit packets, `out_ready_i`=1 -> grant order 0,1,2,3,4,0; each grant lasts 2 cycles plus 1 bubble cycle; `pkt_cnt_o`=5 after the fifth tail.
- Owner 1 locked, sends head, then `req_i[1]`=0 for 10 cycles while `req_i[3]`=1 -> `grant_o` stays 5'b00010, no `fire_o`, input 3 not granted until input 1's tail transfers.
- STALL_MAX=4, locked, `out_ready_i`=0 for 6 cycles -> `stall_o`=1 from the fifth locked no-transfer cycle; raise `out_ready_i` with a body flit -> `stall_o`=0 the next cycle.
- `arst` asserted low mid-packet (owner 2, after 3 flits) -> all outputs 0 immediately, `pkt_cnt_o` unchanged at 0. After release with `req_i`=5'b00110 -> `grant_o`=5'b00010 (rr_ptr reset to 0).
- CNT_W=4, 17 single-flit packets from input 0 -> `pkt_cnt_o` reads 1 after wrap (15 -> 0 -> 1).

Source files
------------

// File: rtl/output_port_arbiter_if.sv
// Request/grant bundle between the input routers and one output-port arbiter.
// The arbiter side uses the slave modport; the router side uses master.
interface output_port_arbiter_if #(
  parameter int N_INPUTS = 5,
  parameter int CNT_W    = 16
);
  logic [N_INPUTS-1:0] req_i;
  logic [N_INPUTS-1:0] tail_i;
  logic                out_ready_i;
  logic [N_INPUTS-1:0] grant_o;
  logic [2:0]          owner_o;
  logic                locked_o;
  logic                fire_o;
  logic                stall_o;
  logic [CNT_W-1:0]    pkt_cnt_o;

  modport master (
    output req_i, tail_i, out_ready_i,
    input  grant_o, owner_o, locked_o, fire_o, stall_o, pkt_cnt_o
  );

  modport slave (
    input  req_i, tail_i, out_ready_i,
    output grant_o, owner_o, locked_o, fire_o, stall_o, pkt_cnt_o
  );
endinterface

// File: rtl/output_port_arbiter.sv
// Round-robin wormhole arbiter for one router output port: locks the port to
// one input from head flit to tail flit, then rotates priority past the owner.
//
// state  | meaning
// IDLE   | port free; arbitrate among req_i starting at rr_ptr
// LOCKED | port held by owner until its tail flit transfers
module output_port_arbiter #(
  parameter int N_INPUTS  = 5,
  parameter int STALL_MAX = 255,
  parameter int CNT_W     = 16
) (
  input logic                 clk,
  input logic                 arst,
  output_port_arbiter_if.slave bus
);

  localparam logic [15:0] STALL_LIM = 16'(STALL_MAX);
  localparam logic [2:0]  LAST_IDX  = 3'(N_INPUTS - 1);
  localparam logic [3:0]  N_WRAP    = 4'(N_INPUTS);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [N_INPUTS-1:0] grant_q, grant_d;
  logic [2:0]          owner_q, owner_d;
  logic [2:0]          rr_q, rr_d;
  logic [CNT_W-1:0]    pkt_q, pkt_d;
  logic [15:0]         stall_cnt_q, stall_cnt_d;
  logic                stall_q, stall_d;
  logic [2:0]          winner;
  logic                found;
  logic                fire;

  // First requester at or after rr_ptr, wrapping at the last input.
  always_comb begin
    logic [3:0] sum;
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      sum = {1'b0, rr_q} + 4'(k);
      if (sum >= N_WRAP) sum = sum - N_WRAP;
      if (!found && bus.req_i[sum[2:0]]) begin
        found  = 1'b1;
        winner = sum[2:0];
      end
    end
  end

  assign fire = (state_q == LOCKED) & bus.req_i[owner_q] & bus.out_ready_i;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    pkt_d       = pkt_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      IDLE: begin
        stall_cnt_d = '0;
        if (found) begin
          state_d         = LOCKED;
          owner_d         = winner;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
        end
      end
      LOCKED: begin
        if (fire) begin
          stall_cnt_d = '0;
          if (bus.tail_i[owner_q]) begin
            state_d = IDLE;
            grant_d = '0;
            rr_d    = (owner_q == LAST_IDX) ? 3'd0 : owner_q + 3'd1;
            pkt_d   = pkt_q + CNT_W'(1);
          end
        end else if (stall_cnt_q != STALL_LIM) begin
          stall_cnt_d = stall_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    stall_d = (stall_cnt_d == STALL_LIM);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_q        <= '0;
      pkt_q       <= '0;
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      pkt_q       <= pkt_d;
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign bus.grant_o   = grant_q;
  assign bus.owner_o   = owner_q;
  assign bus.locked_o  = (state_q == LOCKED);
  assign bus.fire_o    = fire;
  assign bus.stall_o   = stall_q;
  assign bus.pkt_cnt_o = pkt_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!arst)
    $onehot0(grant_q));
  a_grant_locked: assert property (@(posedge clk) disable iff (!arst)
    ((grant_q != '0) == (state_q == LOCKED)));
  a_fire_ready: assert property (@(posedge clk) disable iff (!arst)
    (fire |-> bus.out_ready_i));

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed packets, expected transfers queued
// at issue time and matched by a monitor on every fire_o.
module tb_output_port_arbiter;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  output_port_arbiter_if #(.N_INPUTS(5), .CNT_W(4)) bus ();

  output_port_arbiter #(.N_INPUTS(5), .STALL_MAX(4), .CNT_W(4)) dut (
    .clk (clk),
    .arst(arst),
    .bus (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  int         exp_q[$];
  logic [3:0] exp_pkt  = 4'd0;
  int         order[6] = '{3, 4, 0, 1, 2, 3};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: drive just after the rising edge, return at the sampling edge.
  task automatic step(input logic [4:0] r, input logic [4:0] t, input logic rd);
    @(posedge clk);
    #1;
    bus.req_i       = r;
    bus.tail_i      = t;
    bus.out_ready_i = rd;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    int e;
    if (arst && bus.fire_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_fire: owner %0d fired, no transfer expected", bus.owner_o);
      end else begin
        e = exp_q.pop_front();
        chk("fire_owner", int'(bus.owner_o), e);
        chk("fire_grant", int'(bus.grant_o), 1 << e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst            = 1'b0;
    bus.req_i       = '0;
    bus.tail_i      = '0;
    bus.out_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant",  int'(bus.grant_o), 0);
    chk("rst_locked", int'(bus.locked_o), 0);
    chk("rst_owner",  int'(bus.owner_o), 0);
    chk("rst_stall",  int'(bus.stall_o), 0);
    chk("rst_pkt",    int'(bus.pkt_cnt_o), 0);
    #1 arst = 1'b1;

    // single-flit packet from input 2
    step(5'b00100, 5'b00100, 1'b1);
    chk("t1_idle_grant", int'(bus.grant_o), 0);
    exp_q.push_back(2); exp_pkt++;
    step(5'b00100, 5'b00100, 1'b1);
    chk("t1_grant", int'(bus.grant_o), 'h04);
    chk("t1_locked", int'(bus.locked_o), 1);
    step(5'b00000, 5'b00000, 1'b1);
    chk("t1_release", int'(bus.locked_o), 0);
    chk("t1_pkt", int'(bus.pkt_cnt_o), int'(exp_pkt));

    // all inputs requesting, 2-flit packets; rotation starts at 3
    for (int p = 0; p < 6; p++) begin
      step(5'b11111, 5'b00000, 1'b1);
      chk("t2_bubble", int'(bus.grant_o), 0);
      exp_q.push_back(order[p]);
      step(5'b11111, 5'b00000, 1'b1);
      chk("t2_head_grant", int'(bus.grant_o), 1 << order[p]);
      exp_q.push_back(order[p]); exp_pkt++;
      step(5'b11111, 5'b11111, 1'b1);
    end
    step(5'b00000, 5'b00000, 1'b1);
    chk("t2_pkt", int'(bus.pkt_cnt_o), 7);
    chk("t2_release", int'(bus.locked_o), 0);

    // owner 1 starves mid-packet while input 3 waits
    step(5'b00010, 5'b00000, 1'b1);
    exp_q.push_back(1);
    step(5'b01010, 5'b00000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(5'b01000, 5'b00000, 1'b1);
      chk("t3_hold_grant", int'(bus.grant_o), 'h02);
    end
    exp_q.push_back(1); exp_pkt++;
    step(5'b01010, 5'b00010, 1'b1);
    step(5'b01000, 5'b00000, 1'b1);
    chk("t3_bubble", int'(bus.grant_o), 0);
    exp_q.push_back(3); exp_pkt++;
    step(5'b01000, 5'b01000, 1'b1);
    chk("t3_grant3", int'(bus.grant_o), 'h08);
    step(5'b00000, 5'b00000, 1'b1);
    chk("t3_pkt", int'(bus.pkt_cnt_o), 9);

    // stall detection with STALL_MAX=4
    step(5'b00001, 5'b00000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(5'b00001, 5'b00000, 1'b0);
      chk("t4_stall", int'(bus.stall_o), (i >= 4) ? 1 : 0);
    end
    exp_q.push_back(0);
    step(5'b00001, 5'b00000, 1'b1);
    step(5'b00001, 5'b00000, 1'b0);
    chk("t4_stall_clear", int'(bus.stall_o), 0);
    exp_q.push_back(0); exp_pkt++;
    step(5'b00001, 5'b00001, 1'b1);
    step(5'b00000, 5'b00000, 1'b1);
    chk("t4_pkt", int'(bus.pkt_cnt_o), 10);
    chk("t4_release", int'(bus.locked_o), 0);

    // reset in the middle of a packet from input 2
    step(5'b00100, 5'b00000, 1'b1);
    repeat (3) begin
      exp_q.push_back(2);
      step(5'b00100, 5'b00000, 1'b1);
    end
    @(posedge clk);
    #1 arst = 1'b0;
    #1;
    exp_pkt = 4'd0;
    chk("t5_grant",  int'(bus.grant_o), 0);
    chk("t5_locked", int'(bus.locked_o), 0);
    chk("t5_owner",  int'(bus.owner_o), 0);
    chk("t5_fire",   int'(bus.fire_o), 0);
    chk("t5_pkt",    int'(bus.pkt_cnt_o), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.req_i  = 5'b00110;
    bus.tail_i = 5'b00000;
    arst       = 1'b1;
    @(negedge clk);
    chk("t5_idle_grant", int'(bus.grant_o), 0);
    exp_q.push_back(1); exp_pkt++;
    step(5'b00110, 5'b00010, 1'b1);
    chk("t5_post_rst_grant", int'(bus.grant_o), 'h02);
    step(5'b00100, 5'b00000, 1'b1);
    exp_q.push_back(2); exp_pkt++;
    step(5'b00100, 5'b00100, 1'b1);
    step(5'b00000, 5'b00000, 1'b1);
    chk("t5_pkt_after", int'(bus.pkt_cnt_o), 2);

    // counter wrap: 17 single-flit packets from input 0 after a fresh reset
    @(posedge clk);
    #1 arst = 1'b0;
    exp_pkt = 4'd0;
    @(negedge clk);
    chk("t6_rst_pkt", int'(bus.pkt_cnt_o), 0);
    #1 arst = 1'b1;
    for (int p = 0; p < 17; p++) begin
      step(5'b00001, 5'b00000, 1'b1);
      chk("t6_pkt", int'(bus.pkt_cnt_o), int'(exp_pkt));
      exp_q.push_back(0); exp_pkt++;
      step(5'b00001, 5'b00001, 1'b1);
    end
    step(5'b00000, 5'b00000, 1'b1);
    chk("t6_pkt_wrap", int'(bus.pkt_cnt_o), 1);

    step(5'b00000, 5'b00000, 1'b0);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
